sync_filter: RTL and testbench

- Parametrised multi-bit synchronizer for asynchronous inputs, with a programmable synchronizer depth and per-bit reset values.
- Adds a programmable glitch/stability filter and registered rise/fall/update pulses.
- Sits at the boundary where async control/status inputs (ADC flags, pad levels, slow config buses) enter the clk domain.
- A bus-coherent mode gives a skew-free multi-bit capture for quasi-static buses.

---
 rtl/sync_filter.sv | 117 +++++++++++
 tb/tb_sync_filter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter.sv
// sync_filter: multi-bit async input synchronizer with glitch filter
// and registered rise/fall/update pulses. Per-bit or whole-bus filtering.
module sync_filter #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
    parameter int                    FILT_CNT_W  = 4,
    parameter bit                    BUS_MODE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  filt_en,
    input  logic [FILT_CNT_W-1:0] filt_len,
    output logic [DATA_WIDTH-1:0] dout_sync,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [DATA_WIDTH-1:0] rise,
    output logic [DATA_WIDTH-1:0] fall,
    output logic                  upd
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("sync_filter: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    // One channel per bit, or a single channel spanning the whole bus.
    localparam int NCH = BUS_MODE ? 1 : DATA_WIDTH;
    localparam int CW  = BUS_MODE ? DATA_WIDTH : 1;

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] dout_next;

    assign dout_sync = sync_q[SYNC_STAGES-1];

    // Synchronizer chain: din enters stage 0, dout_sync is the last stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= INIT_VALUE;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    genvar ch;
    generate
        for (ch = 0; ch < NCH; ch++) begin : g_ch
            logic [CW-1:0]         s_c;
            logic [CW-1:0]         dout_c;
            logic [CW-1:0]         cand_q;
            logic [CW-1:0]         cand_n;
            logic [CW-1:0]         dout_n;
            logic [FILT_CNT_W-1:0] cnt_q;
            logic [FILT_CNT_W-1:0] cnt_n;

            assign s_c    = dout_sync[ch*CW +: CW];
            assign dout_c = dout[ch*CW +: CW];
            assign dout_next[ch*CW +: CW] = dout_n;

            // Candidate must stay stable filt_len+2 samples to be accepted;
            // >= lets a lowered filt_len release a pending count at once.
            always_comb begin
                cand_n = cand_q;
                cnt_n  = cnt_q;
                dout_n = dout_c;
                if (!filt_en) begin
                    dout_n = s_c;
                    cand_n = s_c;
                    cnt_n  = '0;
                end else if (s_c != cand_q) begin
                    cand_n = s_c;
                    cnt_n  = '0;
                end else if (cand_q != dout_c) begin
                    if (cnt_q >= filt_len) begin
                        dout_n = cand_q;
                        cnt_n  = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_n = '0;
                end
            end

            // Per-channel candidate and stability counter.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cand_q <= INIT_VALUE[ch*CW +: CW];
                    cnt_q  <= '0;
                end else begin
                    cand_q <= cand_n;
                    cnt_q  <= cnt_n;
                end
            end
        end
    endgenerate

    // Filtered output and edge pulses, registered on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout <= INIT_VALUE;
            rise <= '0;
            fall <= '0;
            upd  <= 1'b0;
        end else begin
            dout <= dout_next;
            rise <= dout_next & ~dout;
            fall <= ~dout_next & dout;
            upd  <= |(dout_next ^ dout);
        end
    end

endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed checks of sync latency, bypass, glitch
// rejection, bus coherence, runtime filt_len change and mid-count reset.
module tb_sync_filter;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    // u0: INIT A5A5, 2 stages, per-bit
    logic [W-1:0] din0, ds0, do0, ri0, fa0;
    logic         fe0, up0;
    logic [3:0]   fl0;
    // u1: INIT 0, 3 stages, per-bit
    logic [W-1:0] din1, ds1, do1, ri1, fa1;
    logic         fe1, up1;
    logic [3:0]   fl1;
    // u2: INIT 0, 2 stages, bus mode
    logic [W-1:0] din2, ds2, do2, ri2, fa2;
    logic         fe2, up2;
    logic [3:0]   fl2;

    sync_filter #(
        .DATA_WIDTH(W), .SYNC_STAGES(2), .INIT_VALUE(16'hA5A5),
        .FILT_CNT_W(4), .BUS_MODE(1'b0)
    ) u0 (
        .clk(clk), .rstn(rstn), .din(din0), .filt_en(fe0),
        .filt_len(fl0), .dout_sync(ds0), .dout(do0),
        .rise(ri0), .fall(fa0), .upd(up0)
    );

    sync_filter #(
        .DATA_WIDTH(W), .SYNC_STAGES(3), .INIT_VALUE(16'h0000),
        .FILT_CNT_W(4), .BUS_MODE(1'b0)
    ) u1 (
        .clk(clk), .rstn(rstn), .din(din1), .filt_en(fe1),
        .filt_len(fl1), .dout_sync(ds1), .dout(do1),
        .rise(ri1), .fall(fa1), .upd(up1)
    );

    sync_filter #(
        .DATA_WIDTH(W), .SYNC_STAGES(2), .INIT_VALUE(16'h0000),
        .FILT_CNT_W(4), .BUS_MODE(1'b1)
    ) u2 (
        .clk(clk), .rstn(rstn), .din(din2), .filt_en(fe2),
        .filt_len(fl2), .dout_sync(ds2), .dout(do2),
        .rise(ri2), .fall(fa2), .upd(up2)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        int seen;
        int bad;
        int nu;
        logic [W-1:0] rr;

        rstn = 1'b0;
        din0 = '0; fe0 = 1'b0; fl0 = 4'd0;
        din1 = '0; fe1 = 1'b1; fl1 = 4'd4;
        din2 = '0; fe2 = 1'b1; fl2 = 4'd1;

        // Reset values
        step(); step();
        chk("rst_dout", do0, 16'hA5A5);
        chk("rst_sync", ds0, 16'hA5A5);
        chk("rst_fall", fa0, 16'h0000);
        chk("rst_upd", 16'(up0), 16'h0000);

        // Bypass latency after release (din0 = 0)
        rstn = 1'b1;
        step();
        chk("byp_e1_sync", ds0, 16'hA5A5);
        step();
        chk("byp_e2_sync", ds0, 16'h0000);
        chk("byp_e2_dout", do0, 16'hA5A5);
        step();
        chk("byp_e3_dout", do0, 16'h0000);
        chk("byp_e3_fall", fa0, 16'hA5A5);
        chk("byp_e3_upd", 16'(up0), 16'h0001);
        chk("byp_e3_rise", ri0, 16'h0000);
        step();
        chk("byp_e4_fall", fa0, 16'h0000);
        chk("byp_e4_upd", 16'(up0), 16'h0000);

        // Filtered latency: 3 stages, filt_len 4 -> dout after edge 9
        din1 = 16'h0001;
        step(); step();
        chk("lat_e2_sync", ds1, 16'h0000);
        step();
        chk("lat_e3_sync", ds1, 16'h0001);
        repeat (5) step();
        chk("lat_e8_dout", do1, 16'h0000);
        step();
        chk("lat_e9_dout", do1, 16'h0001);
        chk("lat_e9_rise", ri1, 16'h0001);
        step();
        chk("lat_e10_rise", ri1, 16'h0000);

        // Glitch of 5 cycles on bit 3 is rejected
        din1 = 16'h0009;
        repeat (5) step();
        din1 = 16'h0001;
        r = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            r += int'(ri1[3]);
            if (do1[3]) seen = 1;
        end
        chk("glitch5_rise", 16'(r), 16'h0000);
        chk("glitch5_dout", 16'(seen), 16'h0000);

        // 6 cycles on bit 3 is accepted, one rise pulse
        din1 = 16'h0009;
        repeat (6) step();
        din1 = 16'h0001;
        r = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            r += int'(ri1[3]);
            if (do1[3]) seen = 1;
        end
        chk("pulse6_rise", 16'(r), 16'h0001);
        chk("pulse6_dout", 16'(seen), 16'h0001);
        chk("pulse6_final", do1, 16'h0001);

        // Bus coherence: bits 7:4 arrive 2 cycles after bits 3:0
        din2 = 16'h000F;
        step(); step();
        din2 = 16'h00FF;
        bad = 0; nu = 0; rr = '0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (do2 == 16'h000F) bad++;
            if (up2) begin
                nu++;
                rr = ri2;
            end
        end
        chk("bus_skew_code", 16'(bad), 16'h0000);
        chk("bus_upd_count", 16'(nu), 16'h0001);
        chk("bus_rise", rr, 16'h00FF);
        chk("bus_dout", do2, 16'h00FF);

        // Lower filt_len from 8 to 2 once cnt reaches 5
        fl1 = 4'd8;
        din1 = 16'h0021;
        repeat (9) step();
        chk("len_cnt5_dout", do1, 16'h0001);
        fl1 = 4'd2;
        step();
        chk("len_drop_dout", do1, 16'h0021);
        chk("len_drop_rise", ri1, 16'h0020);
        step();
        chk("len_after_rise", ri1, 16'h0000);
        chk("len_after_dout", do1, 16'h0021);

        // Reset while counting (cnt = 3)
        fe0 = 1'b1;
        fl0 = 4'd8;
        din0 = 16'hA5A5;
        repeat (6) step();
        chk("rmid_pre_dout", do0, 16'h0000);
        rstn = 1'b0;
        #1;
        chk("rmid_dout", do0, 16'hA5A5);
        chk("rmid_sync", ds0, 16'hA5A5);
        chk("rmid_upd", 16'(up0), 16'h0000);
        chk("rmid_rise", ri0, 16'h0000);
        step();
        rstn = 1'b1;
        nu = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (up0) nu++;
        end
        chk("rmid_no_pulse", 16'(nu), 16'h0000);
        chk("rmid_final", do0, 16'hA5A5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
